// File: rtl/calc_pkg.sv
// Shared types for the calculator entry sequencer: FSM states, ALU opcodes, key codes.
package calc_pkg;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    WAIT_RES = 2'd2,
    SHOW_RES = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4
  } alu_op_t;

  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_MUL = 5'h11;
  localparam logic [4:0] KEY_AND = 5'h12;
  localparam logic [4:0] KEY_EXE = 5'h13;
  localparam logic [4:0] KEY_SUB = 5'h14;
  localparam logic [4:0] KEY_OR  = 5'h15;
  localparam logic [4:0] KEY_CE  = 5'h16;
  localparam logic [4:0] KEY_CLR = 5'h17;

  function automatic logic is_operator(input logic [4:0] key);
    return (key == KEY_ADD) || (key == KEY_MUL) || (key == KEY_AND) ||
           (key == KEY_SUB) || (key == KEY_OR);
  endfunction

  function automatic alu_op_t key_to_aluop(input logic [4:0] key);
    alu_op_t op;
    case (key)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_AND: op = OP_AND;
      KEY_OR:  op = OP_OR;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_digit_reg.sv
// Hex operand register: shifts in one digit per shift pulse until NDIG digits are held.
// Clear beats load beats shift; digits beyond NDIG are dropped. Result visible next cycle.
module calc_digit_reg #(
  parameter int NDIG = 4,
  parameter int W    = 4 * NDIG,
  parameter int CW   = $clog2(NDIG + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          shift,
  input  logic [3:0]    din,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic [CW-1:0] load_cnt,
  output logic [W-1:0]  val,
  output logic [CW-1:0] cnt
);
  import calc_pkg::*;

  logic full;
  assign full = (cnt == CW'(NDIG));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      val <= '0;
      cnt <= '0;
    end else if (load) begin
      val <= load_val;
      cnt <= load_cnt;
    end else if (shift && !full) begin
      val <= {val[W-5:0], din};
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad-to-ALU sequencer: builds operands A/B, starts the ALU on EXE, shows the result.
// One key per key_valid pulse; display lags a key by one cycle. Optional watchdog: CALC_TIMEOUT_EN.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [4:0]          key_val,
  input  logic                alu_done,
  input  logic [8*NDIG-1:0]   alu_result,
  output logic [4*NDIG-1:0]   op_a,
  output logic [4*NDIG-1:0]   op_b,
  output logic [2:0]          alu_op,
  output logic                alu_start,
  output logic [8*NDIG-1:0]   display_val,
  output logic [1:0]          entry_state,
  output logic                busy,
  output logic                err
);
  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);

  if (TIMEOUT_CYC < 2) begin : g_timeout_chk
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_t          state;
  alu_op_t         alu_op_q;
  logic [2*W-1:0]  result_reg;
  logic [2*W-1:0]  disp;

  logic is_dig, is_op, is_exe, is_ce, is_clr;
  assign is_dig = key_valid && (key_val < 5'h10);
  assign is_op  = key_valid && is_operator(key_val);
  assign is_exe = key_valid && (key_val == KEY_EXE);
  assign is_ce  = key_valid && (key_val == KEY_CE);
  assign is_clr = key_valid && (key_val == KEY_CLR);

  logic          a_clr, a_shift, a_load, b_clr, b_shift;
  logic [W-1:0]  a_load_val, a_val, b_val;
  logic [CW-1:0] a_load_cnt, b_cnt, a_cnt_unused;

  always_comb begin
    a_clr      = 1'b0;
    a_shift    = 1'b0;
    a_load     = 1'b0;
    a_load_val = '0;
    a_load_cnt = '0;
    b_clr      = 1'b0;
    b_shift    = 1'b0;
    if (is_clr) begin
      a_clr = 1'b1;
      b_clr = 1'b1;
    end else begin
      case (state)
        ENTER_A: begin
          a_shift = is_dig;
          b_clr   = is_op;
          a_clr   = is_ce;
        end
        ENTER_B: begin
          b_shift = is_dig;
          b_clr   = is_ce;
        end
        SHOW_RES: begin
          // A restarts from the typed digit, or carries the truncated result forward
          if (is_dig) begin
            a_load     = 1'b1;
            a_load_val = {{(W-4){1'b0}}, key_val[3:0]};
            a_load_cnt = CW'(1);
          end else if (is_op || is_exe) begin
            a_load     = 1'b1;
            a_load_val = result_reg[W-1:0];
            a_load_cnt = CW'(NDIG);
            b_clr      = is_op;
          end else if (is_ce) begin
            a_clr = 1'b1;
            b_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  calc_digit_reg #(.NDIG(NDIG)) u_reg_a (
    .clk(clk), .rst(rst), .clr(a_clr), .shift(a_shift), .din(key_val[3:0]),
    .load(a_load), .load_val(a_load_val), .load_cnt(a_load_cnt),
    .val(a_val), .cnt(a_cnt_unused)
  );

  calc_digit_reg #(.NDIG(NDIG)) u_reg_b (
    .clk(clk), .rst(rst), .clr(b_clr), .shift(b_shift), .din(key_val[3:0]),
    .load(1'b0), .load_val('0), .load_cnt('0),
    .val(b_val), .cnt(b_cnt)
  );

  always_comb begin
    disp = '0;
    case (state)
      ENTER_A:  disp = {{W{1'b0}}, a_val};
      ENTER_B:  disp = {{W{1'b0}}, (b_cnt != '0) ? b_val : a_val};
      WAIT_RES: disp = {{W{1'b0}}, b_val};
      default:  disp = result_reg;
    endcase
  end

`ifdef CALC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] wd_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ENTER_A;
      alu_op_q    <= OP_ADD;
      alu_start   <= 1'b0;
      result_reg  <= '0;
      display_val <= '0;
`ifdef CALC_TIMEOUT_EN
      err         <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      alu_start   <= 1'b0;
      display_val <= disp;
`ifdef CALC_TIMEOUT_EN
      wd_cnt <= '0;
      if ((is_dig || is_ce) && state != WAIT_RES)
        err <= 1'b0;
`endif
      if (is_clr || (is_ce && state == SHOW_RES)) begin
        state       <= ENTER_A;
        alu_op_q    <= OP_ADD;
        result_reg  <= '0;
        display_val <= '0;
`ifdef CALC_TIMEOUT_EN
        err         <= 1'b0;
`endif
      end else begin
        case (state)
          ENTER_A: begin
            if (is_op) begin
              alu_op_q <= key_to_aluop(key_val);
              state    <= ENTER_B;
            end
          end
          ENTER_B: begin
            // an operator only replaces the pending one before any B digit
            if (is_op && b_cnt == '0) begin
              alu_op_q <= key_to_aluop(key_val);
            end else if (is_exe && b_cnt != '0) begin
              alu_start <= 1'b1;
              state     <= WAIT_RES;
            end
          end
          WAIT_RES: begin
            if (alu_done) begin
              result_reg <= alu_result;
              state      <= SHOW_RES;
            end
`ifdef CALC_TIMEOUT_EN
            else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
              result_reg <= '0;
              err        <= 1'b1;
              state      <= SHOW_RES;
            end else begin
              wd_cnt <= wd_cnt + WD_W'(1);
            end
`endif
          end
          SHOW_RES: begin
            if (is_dig) begin
              state <= ENTER_A;
            end else if (is_op) begin
              alu_op_q <= key_to_aluop(key_val);
              state    <= ENTER_B;
            end else if (is_exe) begin
              alu_start <= 1'b1;
              state     <= WAIT_RES;
            end
          end
          default: state <= ENTER_A;
        endcase
      end
    end
  end

  assign op_a        = a_val;
  assign op_b        = b_val;
  assign alu_op      = alu_op_q;
  assign entry_state = state;
  assign busy        = (state == WAIT_RES);

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Randomised bench for calc_entry_ctrl: abstract calculator model plus an alu_start scoreboard.
module tb_calc_entry_ctrl;
  localparam int NDIG = 4;
  localparam int S_A = 0, S_B = 1, S_W = 2, S_S = 3;

  logic        clk = 1'b0;
  logic        rst, key_valid, alu_done;
  logic [4:0]  key_val;
  logic [31:0] alu_result, display_val;
  logic [15:0] op_a, op_b;
  logic [2:0]  alu_op;
  logic        alu_start, busy, err;
  logic [1:0]  entry_state;

  always #5 clk = ~clk;

  calc_entry_ctrl #(.NDIG(NDIG), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_val(key_val),
    .alu_done(alu_done), .alu_result(alu_result), .op_a(op_a), .op_b(op_b),
    .alu_op(alu_op), .alu_start(alu_start), .display_val(display_val),
    .entry_state(entry_state), .busy(busy), .err(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // calculator as a user sees it
  int          m_st, m_ca, m_cb, m_op;
  logic [15:0] m_a, m_b;
  logic [31:0] m_res;
  logic        m_err;

  typedef struct { logic [15:0] a; logic [15:0] b; int op; } start_t;
  start_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int op_of(input logic [4:0] k);
    case (k)
      5'h10: return 0;
      5'h14: return 1;
      5'h11: return 2;
      5'h12: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] alu_calc(input logic [15:0] a, input logic [15:0] b, input int op);
    logic [31:0] x, y;
    x = {16'h0, a};
    y = {16'h0, b};
    case (op)
      0: return x + y;
      1: return x - y;
      2: return x * y;
      3: return x & y;
      default: return x | y;
    endcase
  endfunction

  task automatic m_clear();
    m_st = S_A; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_op = 0; m_res = 0; m_err = 0;
  endtask

  task automatic push_start();
    start_t e;
    e.a = m_a; e.b = m_b; e.op = m_op;
    exp_q.push_back(e);
  endtask

  task automatic model_apply(input logic kv, input logic [4:0] k, input logic done, input logic [31:0] res);
    if (kv && k == 5'h17) begin
      m_clear();
    end else if (m_st == S_W) begin
      if (done) begin m_res = res; m_st = S_S; end
    end else if (kv && k <= 5'h17) begin
      if (k < 5'h10 || k == 5'h16) m_err = 0;
      if (k < 5'h10) begin
        if (m_st == S_S) begin
          m_a = {12'h0, k[3:0]}; m_ca = 1; m_st = S_A;
        end else if (m_st == S_A) begin
          if (m_ca < NDIG) begin m_a = {m_a[11:0], k[3:0]}; m_ca++; end
        end else if (m_cb < NDIG) begin
          m_b = {m_b[11:0], k[3:0]}; m_cb++;
        end
      end else if (k == 5'h16) begin
        if (m_st == S_A) begin m_a = 0; m_ca = 0; end
        else if (m_st == S_B) begin m_b = 0; m_cb = 0; end
        else m_clear();
      end else if (k == 5'h13) begin
        if (m_st == S_B && m_cb > 0) begin
          push_start(); m_st = S_W;
        end else if (m_st == S_S) begin
          m_a = m_res[15:0]; m_ca = NDIG; push_start(); m_st = S_W;
        end
      end else begin
        if (m_st == S_A) begin
          m_op = op_of(k); m_b = 0; m_cb = 0; m_st = S_B;
        end else if (m_st == S_B) begin
          if (m_cb == 0) m_op = op_of(k);
        end else begin
          m_a = m_res[15:0]; m_ca = NDIG; m_op = op_of(k); m_b = 0; m_cb = 0; m_st = S_B;
        end
      end
    end
  endtask

  function automatic logic [31:0] m_disp();
    case (m_st)
      S_A: return {16'h0, m_a};
      S_B: return {16'h0, (m_cb > 0) ? m_b : m_a};
      S_W: return {16'h0, m_b};
      default: return m_res;
    endcase
  endfunction

  task automatic check_all();
    chk("entry_state", {30'h0, entry_state}, m_st);
    chk("display_val", display_val, m_disp());
    chk("op_a", {16'h0, op_a}, {16'h0, m_a});
    chk("op_b", {16'h0, op_b}, {16'h0, m_b});
    chk("alu_op", {29'h0, alu_op}, m_op);
    chk("busy", {31'h0, busy}, {31'h0, (m_st == S_W)});
    chk("err", {31'h0, err}, {31'h0, m_err});
  endtask

  task automatic step(input logic kv, input logic [4:0] k, input logic done, input logic [31:0] res);
    @(negedge clk);
    key_valid = kv; key_val = k; alu_done = done; alu_result = res;
    model_apply(kv, k, done, res);
  endtask

  task automatic settle();
    @(negedge clk);
    key_valid = 1'b0; alu_done = 1'b0;
    @(negedge clk);
    check_all();
  endtask

  task automatic press(input logic [4:0] k);
    step(1'b1, k, 1'b0, 32'h0);
    settle();
  endtask

  task automatic respond();
    step(1'b0, 5'h0, 1'b1, alu_calc(m_a, m_b, m_op));
    settle();
  endtask

  // scoreboard monitor: every alu_start must match the oldest predicted start
  logic   prev_start = 1'b0;
  start_t got;
  always @(negedge clk) begin
    if (!rst && alu_start) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL start_unexpected: alu_start=1 with op_a=0x%0h, expected no start", op_a);
      end else begin
        got = exp_q.pop_front();
        chk("start_op_a", {16'h0, op_a}, {16'h0, got.a});
        chk("start_op_b", {16'h0, op_b}, {16'h0, got.b});
        chk("start_alu_op", {29'h0, alu_op}, got.op);
      end
      chk("start_one_cycle", {31'h0, prev_start}, 32'h0);
    end
    prev_start = alu_start && !rst;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench still running, required finish before limit");
    $fatal(1);
  end

  logic [4:0] ops [5] = '{5'h10, 5'h11, 5'h12, 5'h14, 5'h15};
  logic [4:0] k;
  logic       d;
  int         r, w_iters;

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_val = 5'h0; alu_done = 1'b0; alu_result = 32'h0;
    m_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_alu_start", {31'h0, alu_start}, 32'h0);
    check_all();

    // entry and EXE, then result
    press(5'h1); press(5'h2); press(5'h10); press(5'h3); press(5'h13);
    step(1'b0, 5'h0, 1'b1, 32'h15); settle();
    chk("t1_display", display_val, 32'h15);

    // chaining and repeat
    press(5'h11); press(5'h2); press(5'h13); respond();
    press(5'h13); respond();

    // digit overflow
    press(5'h17);
    press(5'h1); press(5'h2); press(5'h3); press(5'h4); press(5'h5);
    chk("t2_display", display_val, 32'h1234);

    // operator replacement and empty-B EXE
    press(5'h10); press(5'h14); press(5'h13);
    chk("t3_alu_op", {29'h0, alu_op}, 32'h1);
    press(5'h7); press(5'h16); press(5'h18); press(5'h9); press(5'h13);

    // CLR in WAIT_RES, then a stale alu_done
    press(5'h17);
    press(5'h2); press(5'h15); press(5'h6); press(5'h13);
    press(5'h17);
    step(1'b0, 5'h0, 1'b1, 32'hABCD); settle();

    // reset in WAIT_RES and mid-entry
    press(5'h3); press(5'h12); press(5'h5); press(5'h13);
    @(negedge clk); rst = 1'b1; m_clear();
    @(negedge clk); rst = 1'b0;
    step(1'b0, 5'h0, 1'b1, 32'h77); settle();
    press(5'h4); press(5'h5);
    @(negedge clk); rst = 1'b1; m_clear();
    @(negedge clk); rst = 1'b0;
    settle();

    // back-to-back pulses, including CLR racing alu_done
    step(1'b1, 5'h8, 1'b0, 0); step(1'b1, 5'h10, 1'b0, 0); step(1'b1, 5'h9, 1'b0, 0);
    step(1'b1, 5'h13, 1'b0, 0); settle();
    step(1'b1, 5'h17, 1'b1, 32'h5555); settle();

`ifdef CALC_TIMEOUT_EN
    press(5'h1); press(5'h10); press(5'h2); press(5'h13);
    repeat (80) @(negedge clk);
    m_res = 0; m_err = 1; m_st = S_S;
    check_all();
    press(5'h7);
    press(5'h17);
`endif

    w_iters = 0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      k = 5'($urandom_range(0, 15));
      else if (r < 75) k = ops[$urandom_range(0, 4)];
      else if (r < 85) k = 5'h13;
      else if (r < 90) k = 5'h16;
      else if (r < 93) k = 5'h17;
      else             k = 5'($urandom_range(24, 31));
      w_iters = (m_st == S_W) ? w_iters + 1 : 0;
      d = (m_st == S_W) ? ($urandom_range(0, 2) == 0 || w_iters > 8) : ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 4) != 0, k, d, (m_st == S_W) ? alu_calc(m_a, m_b, m_op) : 32'($urandom));
      if ($urandom_range(0, 3) != 0) settle();
    end
    settle();
    chk("pending_starts", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
- Sequencer between the keypad grid cursor and the calculator ALU.
- Consumes 5-bit key codes on each select press, builds two hex operands digit by digit, latches the operator and starts the ALU on EXE.
- Waits for the ALU result and selects the value sent to the display.
- Supports chained operations: using the last result as the next A operand.

Parameters:
- NDIG, 4, max hex digits per operand; W = 4*NDIG operand width.
- TIMEOUT_CYC, 64, ALU watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle pulse: key_val is a fresh press
- key_val  in  5  key code: 0x00-0x0F digit, 0x10 ADD, 0x11 MUL, 0x12 AND, 0x13 EXE, 0x14 SUB, 0x15 OR, 0x16 CE, 0x17 CLR; others are ignored
- alu_done  in  1  one-cycle pulse: alu_result is valid
- alu_result  in  2W  ALU result
- op_a  out  W  operand A to the ALU
- op_b  out  W  operand B to the ALU
- alu_op  out  3  ADD=0, SUB=1, MUL=2, AND=3, OR=4
- alu_start  out  1  one-cycle start pulse
- display_val  out  2W  value to show
- entry_state  out  2  current FSM state
- busy  out  1  high in WAIT_RES
- err  out  1  watchdog error flag

Behaviour:
- Reset:
  - All outputs 0; state ENTER_A; digit counters 0.
  - Reset mid-WAIT_RES abandons the operation; a later alu_done is ignored.
- Digit entry (shift): reg = {reg[W-5:0], d}; cnt++.
  - Only when cnt < NDIG; otherwise the digit is dropped and reg is unchanged.
- Global keys:
  - CLR in any state: full reset values except err=0.
  - CE in ENTER_A clears A and cnt_a.
  - CE in ENTER_B clears B and cnt_b.
  - CE in SHOW_RES acts as CLR.
  - CE in WAIT_RES is ignored.
- ENTER_A:
  - digit: shift into A.
  - operator: latch alu_op; B=0, cnt_b=0; go to ENTER_B.
  - EXE: ignored.
- ENTER_B:
  - digit: shift into B.
  - operator: replaces alu_op only if cnt_b==0, else ignored.
  - EXE with cnt_b==0: ignored.
  - EXE with cnt_b>0: alu_start=1 for exactly the next cycle; go to WAIT_RES.
- WAIT_RES:
  - All keys except CLR are ignored.
  - alu_done: result_reg <= alu_result; go to SHOW_RES.
  - alu_done and CLR in the same cycle: CLR wins.
- SHOW_RES:
  - digit: A=d, cnt_a=1; go to ENTER_A.
  - operator: A = result_reg[W-1:0] (truncated), cnt_a=NDIG; latch op; B=0; go to ENTER_B.
  - EXE: A = result_reg[W-1:0]; keep B and op; pulse alu_start; go to WAIT_RES (repeat operation).
- Registers: op_a, op_b and alu_op are stable from the alu_start cycle until alu_done.
- display_val (registered, zero-extended, updated the cycle after each key):
  - ENTER_A: A.
  - ENTER_B: B if cnt_b>0, else A.
  - WAIT_RES: B.
  - SHOW_RES: result_reg.
- Key handling: key_valid with key_val > 0x17 is a no-op. One key is consumed per pulse; back-to-back pulses on consecutive cycles are each processed.

Optional Feature:
- Macro: CALC_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in WAIT_RES.
  - If alu_done has not arrived after TIMEOUT_CYC cycles: result_reg=0, err=1, go to SHOW_RES; a late alu_done is ignored.
  - err clears on the next CE, CLR or digit key.
- Undefined: no counter; WAIT_RES waits indefinitely; err is tied to 0.

Decomposition:
- calc_pkg:
  - state enum (ENTER_A, ENTER_B, WAIT_RES, SHOW_RES).
  - Key code localparams (KEY_ADD..KEY_CLR).
  - alu_op enum.
  - Function key_to_aluop().
- Sub-module calc_digit_reg: parameterised NDIG shift register with count, clear, load-value and full flag. Instantiated twice (A and B).

Test Plan:
1. Entry and EXE: keys 1,2,ADD,3,EXE.
   - Expected: op_a=0x0012, op_b=0x0003, alu_op=0, one alu_start pulse.
   - Then alu_done with result 0x15: display_val=0x15, state SHOW_RES.
2. Digit overflow: keys 1,2,3,4,5 with NDIG=4.
   - Expected: A=0x1234, 5th digit dropped, display 0x1234.
3. Operator edge cases: ADD,SUB before any B digit gives alu_op=1. EXE with no B digit gives no alu_start.
4. Chaining: after result 0x15, press MUL,2,EXE.
   - Expected: op_a=0x0015, op_b=0x0002, alu_op=2.
   - EXE again after the result repeats with op_a=result.
5. CLR during WAIT_RES, then alu_done.
   - Expected: state ENTER_A, all registers 0, result ignored.
   - rst asserted mid-entry gives the same result.
6. Watchdog (CALC_TIMEOUT_EN): no alu_done for 64 cycles.
   - Expected: err=1, display_val=0, state SHOW_RES.
   - Next digit clears err.
